// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alucontrol encoding and execution FSM states
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_BLT = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_LI  = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MIX = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - single-cycle ALU operations and illegal-code detection
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int HALF = WIDTH / 2;

    logic lt;
    assign lt = $signed(srca) < $signed(srcb);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alucontrol)
            ALU_ADD: result = srca + srcb;
            ALU_SUB: result = srca - srcb;
            ALU_AND: result = srca & srcb;
            ALU_OR:  result = srca | srcb;
            ALU_NOR: result = ~(srca | srcb);
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            ALU_BLT: result = {{(WIDTH-1){1'b0}}, lt};
            ALU_LUI: result = {srcb[HALF-1:0], {HALF{1'b0}}};
            ALU_LI:  result = srcb;
            ALU_MIX: result = {srca[WIDTH-1:HALF], srcb[HALF-1:0]};
            // sll with a zero shift amount completes here unshifted
            ALU_SLL: result = srcb;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - handshaked ALU executor with iterative one-bit-per-cycle sll
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    alu_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] core_result;
    logic             core_illegal;
    logic [WIDTH-1:0] shreg_next;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .result     (core_result),
        .illegal    (core_illegal)
    );

    assign shreg_next = {shreg[WIDTH-2:0], 1'b0};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            shreg   <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (alucontrol == ALU_SLL && shamt != '0) begin
                            shreg <= srcb;
                            count <= shamt;
                            state <= SHIFT;
                        end else begin
                            result  <= core_result;
                            zero    <= (core_result == '0);
                            illegal <= core_illegal;
                            state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    count <= count - SHW'(1);
                    // last shift: publish the shifted value on the same edge
                    if (count == SHW'(1)) begin
                        result  <= shreg_next;
                        zero    <= (shreg_next == '0);
                        illegal <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - scoreboard bench for alu_seq_exec
module tb_alu_seq_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] er, input logic ei, input int elat);
        exp_t e;
        e.res  = er;
        e.zero = (er == 32'd0);
        e.ill  = ei;
        e.lat  = elat;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"},     32'(lat),     32'(e.lat));
            chk({tag, "_result"},  result,       e.res);
            chk({tag, "_zero"},    32'(zero),    32'(e.zero));
            chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        end
    endtask

    // Drive one op from IDLE, scramble the inputs after accept, measure latency.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] er, input logic ei, input int elat);
        int lat;
        push_exp(er, ei, elat);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        alucontrol = code;
        srca       = a;
        srcb       = b;
        shamt      = sh;
        chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid   = 1'b0;
        alucontrol = 4'($urandom);
        srca       = $urandom;
        srcb       = $urandom;
        shamt      = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        pop_check(tag, lat);
        tick();
        chk({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_post"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] code, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (code)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return b << sh;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes [5];
        int         stable_bad;
        int         seen_valid;

        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1000};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = 4'b0; srca = 32'd0; srcb = 32'd0; shamt = 5'd0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a long sll
        in_valid = 1'b1; alucontrol = ALU_SLL; srcb = 32'h0000_0003; shamt = 5'd20;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("midshift_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        tick();
        reset = 1'b0;
        seen_valid = 0;
        repeat (25) begin
            tick();
            if (out_valid) seen_valid++;
        end
        chk("midrst_no_output", 32'(seen_valid), 32'd0);

        // Directed ops
        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0, 1);
        run_op("sll_4",    ALU_SLL, 32'd0,         32'h0000_0003, 5'd4,  32'h0000_0030, 1'b0, 5);
        run_op("sll_0",    ALU_SLL, 32'd0,         32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1);
        run_op("sll_31",   ALU_SLL, 32'd0,         32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 32);
        run_op("slt_neg",  ALU_SLT, 32'hFFFF_FFFE, 32'd1,         5'd0,  32'd1,         1'b0, 1);
        run_op("blt_eq",   ALU_BLT, 32'd5,         32'd5,         5'd0,  32'd0,         1'b0, 1);
        run_op("blt_take", ALU_BLT, 32'h8000_0000, 32'd0,         5'd0,  32'd1,         1'b0, 1);
        run_op("lui",      ALU_LUI, 32'd0,         32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0, 1);
        run_op("mix",      ALU_MIX, 32'hAAAA_5555, 32'h1234_BEEF, 5'd0,  32'hAAAA_BEEF, 1'b0, 1);
        run_op("li",       ALU_LI,  32'd0,         32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1);
        run_op("nor",      ALU_NOR, 32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1);
        run_op("sub",      ALU_SUB, 32'd3,         32'd5,         5'd0,  32'hFFFF_FFFE, 1'b0, 1);

        // Illegal code under backpressure, with a competing request held
        push_exp(32'd0, 1'b1, 1);
        out_ready = 1'b0;
        in_valid = 1'b1; alucontrol = 4'b0011; srca = 32'h1111_1111; srcb = 32'h2222_2222;
        tick();
        in_valid = 1'b1; alucontrol = ALU_ADD; srca = 32'd1; srcb = 32'd1;
        pop_check("illegal", out_valid ? 1 : 0);
        stable_bad = 0;
        repeat (10) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd0 ||
                zero !== 1'b1 || illegal !== 1'b1)
                stable_bad++;
        end
        chk("bp_stable", 32'(stable_bad), 32'd0);

        // Release: consumption edge, then the held add is accepted one cycle later
        push_exp(32'd2, 1'b0, 1);
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready",  32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        pop_check("held_add", out_valid ? 1 : 0);
        tick();

        // Random ops against a small reference model
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  s;
            c = codes[$urandom_range(0, 4)];
            a = $urandom;
            b = $urandom;
            s = 5'($urandom);
            run_op($sformatf("rnd%0d", i), c, a, b, s, ref_op(c, a, b, s), 1'b0,
                   (c == ALU_SLL) ? int'(s) + 1 : 1);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution-side consumer of the 4-bit alucontrol code produced by the ALU decoder.
- Accepts one operation per valid/ready handshake and executes it. All ops are single-cycle except sll, which shifts iteratively one bit per cycle.
- Returns result and flags through an output valid/ready handshake.
- Sits between the decode/operand stage and writeback/branch logic of the processor datapath.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation and operands presented.
- in_ready  out  1  block can accept an operation.
- alucontrol  in  4  operation code.
- srca  in  WIDTH  operand A.
- srcb  in  WIDTH  operand B / immediate.
- shamt  in  SHW  shift amount for sll.
- out_valid  out  1  result registered and presented.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  alucontrol was not a defined code.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, result=0, zero=0, illegal=0, out_valid=0, shift register=0, count=0. in_ready=1 once reset is deasserted.
- Reset mid-operation: asserting reset during SHIFT or DONE immediately returns to IDLE and discards the operation. No output handshake occurs for it.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: happens in IDLE when in_valid=1. Operands and code are captured on that edge and must not be re-sampled later.
- Single-cycle codes (result written on the accept edge, then next state DONE):
  - 0010 add: A+B, modulo 2^WIDTH.
  - 0110 sub: A-B, modulo 2^WIDTH.
  - 0000 and: A&B.
  - 0001 or: A|B.
  - 1100 nor: ~(A|B).
  - 0111 slt: 1 if signed(A) < signed(B), else 0, zero-extended.
  - 0101 blt: same compare as slt. zero=1 when the branch is not taken.
  - 1011 lui: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1001 li: B.
  - 1110 mix: {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}.
- 1000 sll:
  - shamt=0: result=B, DONE after 1 cycle.
  - shamt=n>0: shift register loaded with B and count=n, next state SHIFT. Each SHIFT cycle shifts left by 1 with zero fill and decrements count. When count reaches 0 after the shift, result is loaded and next state is DONE.
  - out_valid rises n+1 cycles after the accept edge.
- Any other code: result=0, illegal=1, zero=1, then DONE. No other side effect.
- illegal=0 for every defined code.
- zero is registered together with result and always equals (result==0). This also covers blt: result=0 means not taken.
- DONE: result, zero and illegal are held stable while out_valid=1 and out_ready=0. On out_ready=1 the result is consumed and next state is IDLE.
  - No same-cycle re-accept: a new op may be accepted at the earliest one cycle after consumption. Peak throughput is one op per 2 cycles.
- in_valid while in_ready=0 is ignored. The producer must hold it.
- Inputs are don't-care except on the accept edge.

Decomposition:
- Shared package alu_pkg holds:
  - the alucontrol localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_SLL, ALU_MIX, ALU_LUI, ALU_BLT, ALU_LI);
  - the state enum typedef alu_state_t {IDLE, SHIFT, DONE}.
- The same package is imported by the decoder so both ends share one encoding.
- One sub-module, alu_comb_core: purely combinational single-cycle ops plus the illegal flag. The FSM and shifter stay in alu_seq_exec.

Test Plan:
- Reset and handshake: assert reset mid-SHIFT (sll shamt=20, after 5 cycles) -> state IDLE, out_valid=0 and in_ready=1 at once; no result emitted.
- Add wrap: add A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid one cycle after accept, result=0, zero=1, illegal=0; in_ready back high the following cycle.
- sll latency:
  - sll B=0x00000003, shamt=4 -> out_valid exactly 5 cycles after accept, result=0x00000030.
  - shamt=0 -> 1 cycle, result=B.
  - shamt=31, B=3 -> result=0x80000000.
- Signed compares:
  - slt A=0xFFFFFFFE (-2), B=1 -> result=1, zero=0.
  - blt A=5, B=5 -> result=0, zero=1.
- Remaining ops: lui B=0x00001234 -> 0x12340000; mix A=0xAAAA5555, B=0x1234BEEF -> 0xAAAABEEF; li B=0xDEADBEEF -> 0xDEADBEEF; nor A=0, B=0 -> 0xFFFFFFFF.
- Backpressure and illegal:
  - code 0011 -> illegal=1, result=0.
  - Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a second in_valid is not accepted.
  - Release out_ready -> next op is accepted one cycle later.
